easyaxi_rd_arb: RTL and testbench

Two-master AXI read arbiter that shares one in-order AXI read slave (the outstanding-capable EASYAXI slave) between two AXI read masters. Round-robin arbitration on AR, with a grant lock that holds the AR channel stable until the slave accepts. An order FIFO records which master owns each accepted burst. R beats are routed back to that owner in slave completion order, and the FIFO entry retires on the RLAST handshake.

---
 rtl/easyaxi_rd_arb.sv | 198 +++++++++++++++++++
 tb/tb_easyaxi_rd_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: shares one in-order AXI read slave between two AXI read
// masters. Round-robin AR arbitration with a grant lock that keeps the AR
// channel stable until the slave accepts. A 1-bit-per-entry order FIFO
// records the owner of each accepted burst, and R beats are steered to that
// owner.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_arb #(
    parameter int OST_DEPTH = 8,
    parameter int OST_CNT_W = $clog2(OST_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    // master 0 AR
    input  logic                      m0_arvalid,
    output logic                      m0_arready,
    input  logic [`AXI_ID_W-1:0]      m0_arid,
    input  logic [`AXI_ADDR_W-1:0]    m0_araddr,
    input  logic [`AXI_LEN_W-1:0]     m0_arlen,
    input  logic [`AXI_SIZE_W-1:0]    m0_arsize,
    input  logic [`AXI_BURST_W-1:0]   m0_arburst,
    // master 1 AR
    input  logic                      m1_arvalid,
    output logic                      m1_arready,
    input  logic [`AXI_ID_W-1:0]      m1_arid,
    input  logic [`AXI_ADDR_W-1:0]    m1_araddr,
    input  logic [`AXI_LEN_W-1:0]     m1_arlen,
    input  logic [`AXI_SIZE_W-1:0]    m1_arsize,
    input  logic [`AXI_BURST_W-1:0]   m1_arburst,
    // master 0 R
    output logic                      m0_rvalid,
    input  logic                      m0_rready,
    output logic [`AXI_ID_W-1:0]      m0_rid,
    output logic [`AXI_DATA_W-1:0]    m0_rdata,
    output logic [`AXI_RESP_W-1:0]    m0_rresp,
    output logic                      m0_rlast,
    // master 1 R
    output logic                      m1_rvalid,
    input  logic                      m1_rready,
    output logic [`AXI_ID_W-1:0]      m1_rid,
    output logic [`AXI_DATA_W-1:0]    m1_rdata,
    output logic [`AXI_RESP_W-1:0]    m1_rresp,
    output logic                      m1_rlast,
    // slave AR
    output logic                      s_arvalid,
    input  logic                      s_arready,
    output logic [`AXI_ID_W-1:0]      s_arid,
    output logic [`AXI_ADDR_W-1:0]    s_araddr,
    output logic [`AXI_LEN_W-1:0]     s_arlen,
    output logic [`AXI_SIZE_W-1:0]    s_arsize,
    output logic [`AXI_BURST_W-1:0]   s_arburst,
    // slave R
    input  logic                      s_rvalid,
    output logic                      s_rready,
    input  logic [`AXI_ID_W-1:0]      s_rid,
    input  logic [`AXI_DATA_W-1:0]    s_rdata,
    input  logic [`AXI_RESP_W-1:0]    s_rresp,
    input  logic                      s_rlast
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [OST_CNT_W-1:0] PTR_ONE = {{(OST_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OST_CNT_W:0]   CNT_ONE = {{OST_CNT_W{1'b0}}, 1'b1};

    logic [0:0]           state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 rr_q, rr_d;
    logic [OST_DEPTH-1:0] fifo_q, fifo_d;
    logic [OST_CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OST_CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OST_CNT_W:0]   cnt_q, cnt_d;

    logic full, nonempty, head;
    logic win, sel, ar_hs, push, pop;

    // count never exceeds OST_DEPTH (a power of 2), so its MSB alone means full
    assign full     = cnt_q[OST_CNT_W];
    assign nonempty = (cnt_q != '0);
    assign head     = fifo_q[rd_ptr_q];

    // AR arbitration and payload mux; the lock owns the channel once entered
    always_comb begin
        win = 1'b0;
        if (m0_arvalid && m1_arvalid) win = rr_q;
        else if (m1_arvalid)          win = 1'b1;

        if (state_q == ST_LOCK) begin
            sel       = gnt_q;
            s_arvalid = rst_n;
        end else begin
            sel       = win;
            s_arvalid = rst_n & enable & ~full & (m0_arvalid | m1_arvalid);
        end

        s_arid    = sel ? m1_arid    : m0_arid;
        s_araddr  = sel ? m1_araddr  : m0_araddr;
        s_arlen   = sel ? m1_arlen   : m0_arlen;
        s_arsize  = sel ? m1_arsize  : m0_arsize;
        s_arburst = sel ? m1_arburst : m0_arburst;

        m0_arready = s_arvalid & ~sel & s_arready;
        m1_arready = s_arvalid &  sel & s_arready;
        ar_hs      = s_arvalid & s_arready;
    end

    // R steering from the FIFO head; nothing is forwarded with no burst owed
    always_comb begin
        m0_rvalid = s_rvalid & nonempty & ~head;
        m1_rvalid = s_rvalid & nonempty &  head;
        s_rready  = nonempty & (head ? m1_rready : m0_rready);
        pop       = s_rvalid & s_rready & s_rlast;
        push      = ar_hs;
        m0_rid    = s_rid;   m1_rid   = s_rid;
        m0_rdata  = s_rdata; m1_rdata = s_rdata;
        m0_rresp  = s_rresp; m1_rresp = s_rresp;
        m0_rlast  = s_rlast; m1_rlast = s_rlast;
    end

    // next-state for lock FSM, round-robin pointer and order FIFO
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (state_q == ST_IDLE) begin
            if (s_arvalid && !s_arready) begin
                state_d = ST_LOCK;
                gnt_d   = win;
            end
        end else if (s_arready) begin
            state_d = ST_IDLE;
        end

        if (ar_hs) rr_d = ~sel;

        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            rr_q     <= 1'b0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Directed bench for easyaxi_rd_arb: arbitration, grant lock, full FIFO,
// R routing/backpressure, enable gating and async reset.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_arb;

    logic clk = 1'b0;
    logic rst_n, enable;
    logic m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [`AXI_ID_W-1:0]    m0_arid, m1_arid, s_arid, m0_rid, m1_rid, s_rid;
    logic [`AXI_ADDR_W-1:0]  m0_araddr, m1_araddr, s_araddr;
    logic [`AXI_LEN_W-1:0]   m0_arlen, m1_arlen, s_arlen;
    logic [`AXI_SIZE_W-1:0]  m0_arsize, m1_arsize, s_arsize;
    logic [`AXI_BURST_W-1:0] m0_arburst, m1_arburst, s_arburst;
    logic m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
    logic [`AXI_DATA_W-1:0]  m0_rdata, m1_rdata, s_rdata;
    logic [`AXI_RESP_W-1:0]  m0_rresp, m1_rresp, s_rresp;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    easyaxi_rd_arb #(.OST_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs then change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one R beat owned by `owner`; both masters ready
    task automatic rbeat(input string tag, input logic owner, input logic last);
        s_rvalid = 1'b1; s_rlast = last; m0_rready = 1'b1; m1_rready = 1'b1;
        s_rdata = $urandom;
        #1;
        chk({tag, "_m0v"}, m0_rvalid, !owner);
        chk({tag, "_m1v"}, m1_rvalid, owner);
        chk({tag, "_srdy"}, s_rready, 1'b1);
        chk({tag, "_data"}, owner ? m1_rdata : m0_rdata, s_rdata);
        tick();
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    // single AR handshake from m0 (only requester), s_arready high
    task automatic ar_m0(input logic [`AXI_LEN_W-1:0] len);
        m0_arvalid = 1'b1; m0_arlen = len; s_arready = 1'b1;
        #1;
        chk("ar_m0_rdy", m0_arready, 1'b1);
        chk("ar_m0_len", s_arlen, len);
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1;
        m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
        m0_arid = 4'h1; m0_araddr = 32'h0000_1000; m0_arlen = 0; m0_arsize = 3'd2; m0_arburst = 2'd1;
        m1_arid = 4'h2; m1_araddr = 32'h0000_2000; m1_arlen = 0; m1_arsize = 3'd3; m1_arburst = 2'd1;
        m0_rready = 0; m1_rready = 0;
        s_rvalid = 0; s_rid = 4'h5; s_rdata = 0; s_rresp = 2'd0; s_rlast = 0;

        // ---- reset state: requests and R present, everything held low
        m0_arvalid = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1; m0_rready = 1'b1;
        tick(); #1;
        chk("rst_sarv", s_arvalid, 1'b0);
        chk("rst_m0ardy", m0_arready, 1'b0);
        chk("rst_srrdy", s_rready, 1'b0);
        chk("rst_m0rv", m0_rvalid, 1'b0);
        m0_arvalid = 0; s_arready = 0; s_rvalid = 0; m0_rready = 0;
        rst_n = 1'b1;
        tick();

        // ---- single master: arlen 0, 3, 7
        m0_arvalid = 1'b1; s_arready = 1'b1; m0_arlen = 8'd0;
        #1;
        chk("sm_sarv", s_arvalid, 1'b1);
        chk("sm_m1ardy", m1_arready, 1'b0);
        chk("sm_addr", s_araddr, 32'h0000_1000);
        chk("sm_id", s_arid, 4'h1);
        m0_arvalid = 1'b0; s_arready = 1'b0;
        ar_m0(8'd0);
        ar_m0(8'd3);
        ar_m0(8'd7);
        // m0_rready low stalls s_rready; rid passes through
        s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b0; m1_rready = 1'b1;
        #1;
        chk("sm_bp_srdy", s_rready, 1'b0);
        chk("sm_bp_m1v", m1_rvalid, 1'b0);
        chk("sm_rid", m0_rid, 4'h5);
        s_rvalid = 1'b0;
        rbeat("sm_b0", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rbeat("sm_b1", 1'b0, i == 3);
        for (int i = 0; i < 8; i++) rbeat("sm_b2", 1'b0, i == 7);
        // count back at 0: a stray beat is not forwarded
        s_rvalid = 1'b1; m0_rready = 1'b1; #1;
        chk("sm_empty_srdy", s_rready, 1'b0);
        chk("sm_empty_m0v", m0_rvalid, 1'b0);
        s_rvalid = 1'b0;

        // ---- contention from fresh reset: m0, m1, m0, m1
        do_reset();
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ct_id", s_arid, (i % 2) ? 4'h2 : 4'h1);
            chk("ct_m0rdy", m0_arready, (i % 2) ? 1'b0 : 1'b1);
            chk("ct_m1rdy", m1_arready, (i % 2) ? 1'b1 : 1'b0);
            tick();
        end
        m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
        rbeat("ct_r0", 1'b0, 1'b1);
        rbeat("ct_r1", 1'b1, 1'b1);
        rbeat("ct_r2", 1'b0, 1'b1);
        rbeat("ct_r3", 1'b1, 1'b1);

        // ---- grant lock: one m0 grant makes m1 next priority
        ar_m0(8'd0);
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable = (i != 2);  // dropping enable must not drop a locked AR
            #1;
            chk("lk_sarv", s_arvalid, 1'b1);
            chk("lk_addr", s_araddr, 32'h0000_2000);
            chk("lk_m0rdy", m0_arready, 1'b0);
            tick();
        end
        enable = 1'b1; s_arready = 1'b1;
        #1;
        chk("lk_m1hs", m1_arready, 1'b1);
        chk("lk_m0hs", m0_arready, 1'b0);
        tick();
        #1;
        chk("lk_next_m0", m0_arready, 1'b1);
        chk("lk_next_addr", s_araddr, 32'h0000_1000);
        tick();
        m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
        rbeat("lk_r0", 1'b0, 1'b1);
        rbeat("lk_r1", 1'b1, 1'b1);
        rbeat("lk_r2", 1'b0, 1'b1);

        // ---- full: 8 accepted, 9th blocked until one RLAST pop
        for (int i = 0; i < 8; i++) ar_m0(8'd0);
        m0_arvalid = 1'b1; s_arready = 1'b1;
        #1;
        chk("fu_sarv", s_arvalid, 1'b0);
        chk("fu_m0rdy", m0_arready, 1'b0);
        s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b1;
        #1;
        chk("fu_pop_sarv", s_arvalid, 1'b0);
        tick();
        s_rvalid = 1'b0;
        #1;
        chk("fu_after_m0rdy", m0_arready, 1'b1);
        tick();
        m0_arvalid = 0; s_arready = 0;
        for (int i = 0; i < 8; i++) rbeat("fu_drain", 1'b0, 1'b1);

        // ---- m1 8-beat burst with toggling rready; enable=0 blocks m0 AR
        m1_arvalid = 1'b1; m1_arlen = 8'd7; s_arready = 1'b1;
        #1;
        chk("bp_m1hs", m1_arready, 1'b1);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b1;
        enable = 1'b0; m0_arvalid = 1'b1;
        begin
            int beats = 0;
            int cyc = 0;
            while (beats < 8 && cyc < 40) begin
                s_rvalid = 1'b1; s_rlast = (beats == 7);
                m1_rready = cyc[0] ? 1'b0 : 1'b1; m0_rready = 1'b1;
                #1;
                chk("bp_srdy", s_rready, m1_rready);
                chk("bp_m0v", m0_rvalid, 1'b0);
                chk("bp_en_sarv", s_arvalid, 1'b0);
                if (s_rready) beats++;
                tick();
                cyc++;
            end
            chk("bp_beats", beats, 8);
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        enable = 1'b1;
        #1;
        chk("en_back_m0rdy", m0_arready, 1'b1);
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
        rbeat("en_r0", 1'b0, 1'b1);

        // ---- reset during a locked AR and a half-finished R burst
        m1_arvalid = 1'b1; m1_arlen = 8'd3; s_arready = 1'b1;
        tick();
        m1_arvalid = 1'b0;
        rbeat("rm_b0", 1'b1, 1'b0);
        m0_arvalid = 1'b1; s_arready = 1'b0;
        tick();  // m0 now locked
        s_rvalid = 1'b1; m1_rready = 1'b1;
        #1;
        chk("rm_pre_m1v", m1_rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_sarv", s_arvalid, 1'b0);
        chk("rm_srrdy", s_rready, 1'b0);
        chk("rm_m1v", m1_rvalid, 1'b0);
        chk("rm_m0rdy", m0_arready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        // count cleared: beat ignored; rr cleared: m0 wins contention
        m1_arvalid = 1'b1; s_arready = 1'b1;
        #1;
        chk("rm_post_m1v", m1_rvalid, 1'b0);
        chk("rm_post_srdy", s_rready, 1'b0);
        chk("rm_post_rr", m0_arready, 1'b1);
        tick();
        m0_arvalid = 0; m1_arvalid = 0; s_arready = 0; s_rvalid = 0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
